// File: rtl/bcd_pkg.sv
// Shared definitions for the sequential binary-to-BCD converter:
// state encoding, add-3 constants and a digit-count helper for integrators.
package bcd_pkg;

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_SHIFT = 2'd1;
   localparam logic [1:0] S_DONE  = 2'd2;

   typedef enum logic [1:0] {
      IDLE  = S_IDLE,
      SHIFT = S_SHIFT,
      DONE  = S_DONE
   } state_e;

   localparam logic [3:0] ADD3_THRESH = 4'd4;
   localparam logic [3:0] ADD3_VAL    = 4'd3;

   // Decimal digits required to show the largest BIN_W-bit unsigned value.
   function automatic int bcd_digits_needed(input int bin_w);
      longint unsigned maxv;
      int              d;
      maxv = (64'd1 << bin_w) - 64'd1;
      d    = 1;
      for (int i = 0; i < 20; i++) begin
         if (maxv >= 64'd10) begin
            maxv = maxv / 64'd10;
            d    = d + 1;
         end
      end
      return d;
   endfunction

endpackage

// File: rtl/bcd_add3_digit.sv
// One BCD correction cell: digits above four get three added so the next
// left shift carries correctly into the following decade.
module bcd_add3_digit
   import bcd_pkg::*;
(
   input  logic [3:0] digit_i,
   output logic [3:0] digit_o
);

   always_comb begin
      if (digit_i > ADD3_THRESH) begin
         digit_o = digit_i + ADD3_VAL;
      end else begin
         digit_o = digit_i;
      end
   end

endmodule

// File: rtl/bcd_seq_converter.sv
// Iterative shift-and-add-3 binary-to-BCD converter, one operand bit per clock,
// with optional two's-complement input and a sticky overflow flag.
module bcd_seq_converter
   import bcd_pkg::*;
#(
   parameter int BIN_W  = 16,
   parameter int DIGITS = 5,
   parameter int SIGNED = 0
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic [BIN_W-1:0]      bin_in,
   output logic                  ready,
   output logic                  busy,
   output logic                  done,
   output logic [4*DIGITS-1:0]   bcd_out,
   output logic                  sign,
   output logic                  overflow
);

   localparam int SW    = 4 * DIGITS;
   localparam int CNT_W = $clog2(BIN_W);

   state_e             state_q;
   logic [CNT_W-1:0]   cnt_q;
   logic [BIN_W-1:0]   bin_q;
   logic [SW-1:0]      scr_q;
   logic               ovf_q;
   logic               neg_q;
   logic               ready_q;
   logic               busy_q;
   logic               done_q;
   logic [SW-1:0]      bcd_out_q;
   logic               sign_q;
   logic               overflow_q;

   logic [SW-1:0]      corr_d;
   logic [SW-1:0]      scr_d;
   logic [BIN_W-1:0]   bin_d;
   logic               carry_d;
   logic [BIN_W-1:0]   mag_d;
   logic               neg_d;

   for (genvar g = 0; g < DIGITS; g++) begin : g_add3
      bcd_add3_digit u_add3 (
         .digit_i (scr_q[4*g +: 4]),
         .digit_o (corr_d[4*g +: 4])
      );
   end

   // Corrected scratch shifted left with the next operand bit entering at the units end.
   always_comb begin
      scr_d   = {corr_d[SW-2:0], bin_q[BIN_W-1]};
      bin_d   = {bin_q[BIN_W-2:0], 1'b0};
      carry_d = corr_d[SW-1];
   end

   // Magnitude is taken modulo 2^BIN_W so the most negative value converts exactly.
   always_comb begin
      if ((SIGNED != 0) && bin_in[BIN_W-1]) begin
         mag_d = -bin_in;
         neg_d = 1'b1;
      end else begin
         mag_d = bin_in;
         neg_d = 1'b0;
      end
   end

   // Control FSM with registered handshake and result outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         cnt_q      <= {CNT_W{1'b0}};
         bin_q      <= {BIN_W{1'b0}};
         scr_q      <= {SW{1'b0}};
         ovf_q      <= 1'b0;
         neg_q      <= 1'b0;
         ready_q    <= 1'b1;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         bcd_out_q  <= {SW{1'b0}};
         sign_q     <= 1'b0;
         overflow_q <= 1'b0;
      end else begin
         case (state_q)
            IDLE, DONE: begin
               done_q <= 1'b0;
               if (start) begin
                  state_q <= SHIFT;
                  cnt_q   <= CNT_W'(BIN_W - 1);
                  bin_q   <= mag_d;
                  scr_q   <= {SW{1'b0}};
                  ovf_q   <= 1'b0;
                  neg_q   <= neg_d;
                  ready_q <= 1'b0;
                  busy_q  <= 1'b1;
               end else begin
                  state_q <= IDLE;
                  ready_q <= 1'b1;
                  busy_q  <= 1'b0;
               end
            end
            SHIFT: begin
               scr_q <= scr_d;
               bin_q <= bin_d;
               ovf_q <= ovf_q | carry_d;
               if (cnt_q == {CNT_W{1'b0}}) begin
                  state_q    <= DONE;
                  ready_q    <= 1'b1;
                  busy_q     <= 1'b0;
                  done_q     <= 1'b1;
                  bcd_out_q  <= scr_d;
                  sign_q     <= neg_q;
                  overflow_q <= ovf_q | carry_d;
               end else begin
                  cnt_q <= cnt_q - CNT_W'(1);
               end
            end
            default: begin
               state_q <= IDLE;
               ready_q <= 1'b1;
               busy_q  <= 1'b0;
               done_q  <= 1'b0;
            end
         endcase
      end
   end

   assign ready    = ready_q;
   assign busy     = busy_q;
   assign done     = done_q;
   assign bcd_out  = bcd_out_q;
   assign sign     = sign_q;
   assign overflow = overflow_q;

endmodule

// File: tb/tb_bcd_seq_converter.sv
// Bench for bcd_seq_converter: three configurations driven in parallel and
// checked every cycle against a decimal-arithmetic reference model.
module tb_bcd_seq_converter;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start;
   logic [15:0] bin_in;

   logic        r0, b0, d0, s0, v0;
   logic [19:0] o0;
   logic        r1, b1, d1, s1, v1;
   logic [15:0] o1;
   logic        r2, b2, d2, s2, v2;
   logic [19:0] o2;

   int tests = 0;
   int fails = 0;
   int ncyc  = 0;

   always #5 clk = ~clk;

   bcd_seq_converter #(.BIN_W(16), .DIGITS(5), .SIGNED(0)) u0 (
      .clk(clk), .rst_n(rst_n), .start(start), .bin_in(bin_in),
      .ready(r0), .busy(b0), .done(d0), .bcd_out(o0), .sign(s0), .overflow(v0));
   bcd_seq_converter #(.BIN_W(16), .DIGITS(4), .SIGNED(0)) u1 (
      .clk(clk), .rst_n(rst_n), .start(start), .bin_in(bin_in),
      .ready(r1), .busy(b1), .done(d1), .bcd_out(o1), .sign(s1), .overflow(v1));
   bcd_seq_converter #(.BIN_W(16), .DIGITS(5), .SIGNED(1)) u2 (
      .clk(clk), .rst_n(rst_n), .start(start), .bin_in(bin_in),
      .ready(r2), .busy(b2), .done(d2), .bcd_out(o2), .sign(s2), .overflow(v2));

   // Returns {overflow, sign, bcd[19:0]} computed with plain decimal arithmetic.
   function automatic logic [21:0] ref_conv(input logic [15:0] b, input int nd, input bit sg);
      int unsigned mag, lim, t;
      logic        neg;
      logic [19:0] r;
      neg = sg && b[15];
      mag = neg ? (32'd65536 - {16'd0, b}) : {16'd0, b};
      lim = 1;
      for (int i = 0; i < nd; i++) lim = lim * 10;
      r = 20'd0;
      t = mag;
      for (int i = 0; i < nd; i++) begin
         r[4*i +: 4] = 4'(t % 10);
         t = t / 10;
      end
      return {(mag >= lim), neg, r};
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s actual=%h required=%h", nm, act, exp);
      end
   endtask

   // Reference model: timing by countdown, results from ref_conv.
   int          m_left;
   logic        m_ready, m_done;
   logic [21:0] m_pend0, m_pend1, m_pend2;
   logic [21:0] m_out0, m_out1, m_out2;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_left  <= 0;
         m_ready <= 1'b1;
         m_done  <= 1'b0;
         m_out0  <= 22'd0;
         m_out1  <= 22'd0;
         m_out2  <= 22'd0;
      end else if (m_left > 0) begin
         m_left <= m_left - 1;
         if (m_left == 1) begin
            m_done  <= 1'b1;
            m_ready <= 1'b1;
            m_out0  <= m_pend0;
            m_out1  <= m_pend1;
            m_out2  <= m_pend2;
         end else begin
            m_done <= 1'b0;
         end
      end else if (m_ready && start) begin
         m_left  <= 16;
         m_ready <= 1'b0;
         m_done  <= 1'b0;
         m_pend0 <= ref_conv(bin_in, 5, 1'b0);
         m_pend1 <= ref_conv(bin_in, 4, 1'b0);
         m_pend2 <= ref_conv(bin_in, 5, 1'b1);
      end else begin
         m_done  <= 1'b0;
         m_ready <= 1'b1;
      end
   end

   always @(posedge clk) ncyc <= ncyc + 1;

   // Per-cycle comparison of all three instances against the model.
   always @(negedge clk) begin
      if (rst_n) begin
         chk("u0_ready", {31'd0, r0}, {31'd0, m_ready});
         chk("u0_busy",  {31'd0, b0}, {31'd0, ~m_ready});
         chk("u0_done",  {31'd0, d0}, {31'd0, m_done});
         chk("u0_result", {10'd0, v0, s0, o0}, {10'd0, m_out0});
         chk("u1_ready", {31'd0, r1}, {31'd0, m_ready});
         chk("u1_done",  {31'd0, d1}, {31'd0, m_done});
         chk("u1_result", {14'd0, v1, s1, o1}, {14'd0, m_out1[21:20], m_out1[15:0]});
         chk("u2_busy",  {31'd0, b2}, {31'd0, ~m_ready});
         chk("u2_done",  {31'd0, d2}, {31'd0, m_done});
         chk("u2_result", {10'd0, v2, s2, o2}, {10'd0, m_out2});
      end
   end

   task automatic wait_done(input string nm, output int at);
      at = -1;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (d0) begin
            at = ncyc;
            break;
         end
      end
      if (at < 0) chk({nm, "_timeout"}, 32'd0, 32'd1);
   endtask

   task automatic convert(input logic [15:0] v, output int lat);
      int t0, t1;
      @(posedge clk);
      #1 start = 1'b1;
      bin_in = v;
      @(posedge clk);
      #1 start = 1'b0;
      t0 = ncyc;
      wait_done("convert", t1);
      lat = t1 - t0;
   endtask

   int lat, ta, tb2, dcount;
   logic [15:0] corner [6] = '{16'h0000, 16'hFFFF, 16'h8000, 16'h7FFF, 16'd9999, 16'd10000};

   initial begin
      rst_n  = 1'b0;
      start  = 1'b0;
      bin_in = 16'd0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_ready", {31'd0, r0}, 32'd1);
      chk("rst_busy",  {31'd0, b0}, 32'd0);
      chk("rst_done",  {31'd0, d0}, 32'd0);
      chk("rst_out",   {10'd0, v0, s0, o0}, 32'd0);
      rst_n = 1'b1;

      convert(16'h04D2, lat);
      chk("lat_1234", lat, 32'd16);
      chk("bcd_1234", {12'd0, o0}, 32'h01234);

      convert(16'hFFFF, lat);
      chk("bcd_65535", {12'd0, o0}, 32'h65535);
      chk("ovf_65535_d5", {31'd0, v0}, 32'd0);
      chk("bcd_65535_d4", {16'd0, o1}, 32'h5535);
      chk("ovf_65535_d4", {31'd0, v1}, 32'd1);

      convert(16'h0000, lat);
      chk("bcd_zero", {12'd0, o0}, 32'h00000);
      chk("sign_zero_signed", {31'd0, s2}, 32'd0);

      convert(16'd9999, lat);
      chk("bcd_9999_d4", {16'd0, o1}, 32'h9999);
      chk("ovf_9999_d4", {31'd0, v1}, 32'd0);

      convert(16'hFB2E, lat);
      chk("sign_m1234", {31'd0, s2}, 32'd1);
      chk("bcd_m1234", {12'd0, o2}, 32'h01234);
      chk("sign_unsigned", {31'd0, s0}, 32'd0);

      convert(16'h8000, lat);
      chk("sign_m32768", {31'd0, s2}, 32'd1);
      chk("bcd_m32768", {12'd0, o2}, 32'h32768);

      // start while busy must be ignored
      @(posedge clk);
      #1 start = 1'b1;
      bin_in = 16'h04D2;
      @(posedge clk);
      #1 start = 1'b0;
      repeat (5) @(posedge clk);
      #1 start = 1'b1;
      bin_in = 16'hFFFF;
      @(posedge clk);
      #1 start = 1'b0;
      wait_done("ignore", ta);
      chk("ignore_busy", {12'd0, o0}, 32'h01234);

      // start held through DONE: back-to-back throughput
      @(posedge clk);
      #1 start = 1'b1;
      bin_in = 16'd4321;
      wait_done("b2b_a", ta);
      bin_in = 16'd777;
      wait_done("b2b_b", tb2);
      @(posedge clk);
      #1 start = 1'b0;
      chk("b2b_period", tb2 - ta, 32'd17);
      chk("b2b_result", {12'd0, o0}, 32'h00777);
      repeat (20) @(posedge clk);

      // asynchronous reset in the middle of a conversion
      #1 start = 1'b1;
      bin_in = 16'h1234;
      @(posedge clk);
      #1 start = 1'b0;
      repeat (8) @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("abort_ready", {31'd0, r0}, 32'd1);
      chk("abort_busy",  {31'd0, b0}, 32'd0);
      chk("abort_out",   {10'd0, v0, s0, o0}, 32'd0);
      @(posedge clk);
      #3 rst_n = 1'b1;
      dcount = 0;
      for (int i = 0; i < 30; i++) begin
         @(negedge clk);
         if (d0) dcount++;
      end
      chk("abort_no_done", dcount, 32'd0);

      // randomized traffic checked by the per-cycle compare
      for (int i = 0; i < 1500; i++) begin
         @(posedge clk);
         #1 start = ($urandom_range(0, 3) == 0);
         if ($urandom_range(0, 4) == 0) bin_in = corner[$urandom_range(0, 5)];
         else bin_in = 16'($urandom);
      end
      #1 start = 1'b0;
      repeat (20) @(posedge clk);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
